// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and state type for the Ethernet/IPv4/UDP receiver
package eth_pkg;

  localparam int PRE_N   = 8;
  localparam int MAC_N   = 12;
  localparam int VLAN_N  = 4;
  localparam int ETYPE_N = 2;
  localparam int IP_N    = 20;
  localparam int UDP_N   = 8;

  localparam int IP_PROTO_OFF  = 9;
  localparam int IP_DST_OFF    = 16;
  localparam int UDP_DPORT_OFF = 2;
  localparam int UDP_LEN_OFF   = 4;

  localparam logic [7:0]  PREAMBLE   = 8'h55;
  localparam logic [7:0]  SFD        = 8'hD5;
  localparam logic [7:0]  IP_VER_IHL = 8'h45;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;
  localparam logic [15:0] TPID       = 16'h8100;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_e;

  function automatic int head_n(input int vlan);
    return PRE_N + MAC_N + ((vlan != 0) ? VLAN_N : 0) + ETYPE_N + IP_N + UDP_N;
  endfunction

endpackage

// File: rtl/eth_rx_head_chk.sv
// rtl/eth_rx_head_chk.sv - combinational header field matcher for one datapath word
module eth_rx_head_chk
  import eth_pkg::*;
#(
  parameter int          VLAN_TAG = 1,
  parameter int          DATA_W   = 16,
  parameter logic [47:0] MAC_ADDR = 48'h000000FCD4F2,
  parameter logic [31:0] IP_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [15:0] PORT     = 16'd18170,
  parameter int          CNT_W    = 5
) (
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [15:0]       udp_len_i,
  output logic              match_o,
  output logic [15:0]       udp_len_o
);

  localparam int KEEP_W    = DATA_W / 8;
  localparam int TPID_OFF  = PRE_N + MAC_N;
  localparam int ETYPE_OFF = TPID_OFF + ((VLAN_TAG != 0) ? VLAN_N : 0);
  localparam int IP_OFF    = ETYPE_OFF + ETYPE_N;
  localparam int UDP_OFF   = IP_OFF + IP_N;
  localparam int IPD_OFF   = IP_OFF + IP_DST_OFF;

  // Each byte lane is checked against the field expected at its absolute header offset
  always_comb begin
    int         idx;
    logic [7:0] b;
    idx       = 0;
    b         = '0;
    match_o   = 1'b1;
    udp_len_o = udp_len_i;
    for (int i = 0; i < KEEP_W; i++) begin
      idx = int'(cnt_i) * KEEP_W + i;
      b   = data_i[8*i +: 8];
      if (idx < PRE_N - 1) begin
        if (b != PREAMBLE) match_o = 1'b0;
      end else if (idx == PRE_N - 1) begin
        if (b != SFD) match_o = 1'b0;
      end else if (idx >= PRE_N && idx < PRE_N + 6) begin
        if (b != MAC_ADDR[8*(PRE_N+5-idx) +: 8]) match_o = 1'b0;
      end else if (VLAN_TAG != 0 && idx == TPID_OFF) begin
        if (b != TPID[15:8]) match_o = 1'b0;
      end else if (VLAN_TAG != 0 && idx == TPID_OFF + 1) begin
        if (b != TPID[7:0]) match_o = 1'b0;
      end else if (idx == ETYPE_OFF) begin
        if (b != ETYPE_IPV4[15:8]) match_o = 1'b0;
      end else if (idx == ETYPE_OFF + 1) begin
        if (b != ETYPE_IPV4[7:0]) match_o = 1'b0;
      end else if (idx == IP_OFF) begin
        if (b != IP_VER_IHL) match_o = 1'b0;
      end else if (idx == IP_OFF + IP_PROTO_OFF) begin
        if (b != PROTO_UDP) match_o = 1'b0;
      end else if (idx >= IPD_OFF && idx < IPD_OFF + 4) begin
        if (b != IP_ADDR[8*(IPD_OFF+3-idx) +: 8]) match_o = 1'b0;
      end else if (idx == UDP_OFF + UDP_DPORT_OFF) begin
        if (b != PORT[15:8]) match_o = 1'b0;
      end else if (idx == UDP_OFF + UDP_DPORT_OFF + 1) begin
        if (b != PORT[7:0]) match_o = 1'b0;
      end else if (idx == UDP_OFF + UDP_LEN_OFF) begin
        udp_len_o[15:8] = b;
      end else if (idx == UDP_OFF + UDP_LEN_OFF + 1) begin
        udp_len_o[7:0] = b;
      end
    end
  end

endmodule

// File: rtl/eth_rx.sv
// rtl/eth_rx.sv - Ethernet/IPv4/UDP receive filter that strips headers and forwards the UDP payload
module eth_rx
  import eth_pkg::*;
#(
  parameter int          VLAN_TAG = 1,
  parameter int          DATA_W   = 16,
  parameter logic [47:0] MAC_ADDR = 48'h000000FCD4F2,
  parameter logic [31:0] IP_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [15:0] PORT     = 16'd18170,
  localparam int         KEEP_W   = DATA_W / 8,
  localparam int         LEN_W    = $clog2(KEEP_W + 1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              pcs_valid_i,
  input  logic              pcs_start_i,
  input  logic [DATA_W-1:0] pcs_data_i,
  input  logic [LEN_W-1:0]  pcs_len_i,
  input  logic              pcs_last_i,
  output logic              app_valid_o,
  output logic [DATA_W-1:0] app_data_o,
  output logic [LEN_W-1:0]  app_len_o,
  output logic              app_start_o,
  output logic              app_last_o,
  output logic              app_cancel_o,
  output logic [15:0]       pkt_len_o
);

  localparam int               HEAD_WORDS = head_n(VLAN_TAG) / KEEP_W;
  localparam int               CNT_W      = $clog2(HEAD_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(HEAD_WORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, chk_cnt;
  logic [15:0]         udp_len_q, udp_len_d, chk_udp_len;
  logic [15:0]         pkt_len_q, pkt_len_d;
  logic                first_q, first_d;
  logic                chk_match;
  logic                emit;
  logic                app_valid_q, app_valid_d;
  logic [DATA_W-1:0]   app_data_q, app_data_d;
  logic [LEN_W-1:0]    app_len_q, app_len_d;
  logic                app_start_q, app_start_d;
  logic                app_last_q, app_last_d;
  logic                app_cancel_q, app_cancel_d;

  // A start word is always header word 0, whatever the counter holds
  assign chk_cnt = pcs_start_i ? '0 : cnt_q;

  eth_rx_head_chk #(
    .VLAN_TAG (VLAN_TAG),
    .DATA_W   (DATA_W),
    .MAC_ADDR (MAC_ADDR),
    .IP_ADDR  (IP_ADDR),
    .PORT     (PORT),
    .CNT_W    (CNT_W)
  ) u_head_chk (
    .cnt_i     (chk_cnt),
    .data_i    (pcs_data_i),
    .udp_len_i (udp_len_q),
    .match_o   (chk_match),
    .udp_len_o (chk_udp_len)
  );

  // Payload words are forwarded only in DATA and never for a restart word
  assign emit = pcs_valid_i & ~pcs_start_i & (state_q == DATA);

  // Next-state logic: last has priority, then restart, then per-state header walk
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    udp_len_d    = udp_len_q;
    pkt_len_d    = pkt_len_q;
    first_d      = first_q;
    app_valid_d  = 1'b0;
    app_data_d   = app_data_q;
    app_len_d    = app_len_q;
    app_start_d  = 1'b0;
    app_last_d   = 1'b0;
    app_cancel_d = 1'b0;

    if (pcs_valid_i) begin
      if (pcs_last_i) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (pcs_start_i) begin
        app_cancel_d = (state_q == DATA);
        udp_len_d    = chk_udp_len;
        first_d      = 1'b1;
        cnt_d        = CNT_W'(1);
        state_d      = chk_match ? HEAD : DROP;
      end else if (state_q == HEAD) begin
        udp_len_d = chk_udp_len;
        if (!chk_match) begin
          state_d = DROP;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (emit) begin
      app_valid_d = 1'b1;
      app_data_d  = pcs_data_i;
      app_start_d = first_q;
      app_last_d  = pcs_last_i;
      app_len_d   = pcs_last_i ? pcs_len_i : LEN_W'(KEEP_W);
      first_d     = 1'b0;
      if (first_q) pkt_len_d = udp_len_q - 16'd8;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      udp_len_q    <= '0;
      pkt_len_q    <= '0;
      first_q      <= 1'b0;
      app_valid_q  <= 1'b0;
      app_data_q   <= '0;
      app_len_q    <= '0;
      app_start_q  <= 1'b0;
      app_last_q   <= 1'b0;
      app_cancel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      udp_len_q    <= udp_len_d;
      pkt_len_q    <= pkt_len_d;
      first_q      <= first_d;
      app_valid_q  <= app_valid_d;
      app_data_q   <= app_data_d;
      app_len_q    <= app_len_d;
      app_start_q  <= app_start_d;
      app_last_q   <= app_last_d;
      app_cancel_q <= app_cancel_d;
    end
  end

  assign app_valid_o  = app_valid_q;
  assign app_data_o   = app_data_q;
  assign app_len_o    = app_len_q;
  assign app_start_o  = app_start_q;
  assign app_last_o   = app_last_q;
  assign app_cancel_o = app_cancel_q;
  assign pkt_len_o    = pkt_len_q;

endmodule

// File: tb/tb_eth_rx.sv
// tb/tb_eth_rx.sv - randomized self-checking bench for eth_rx against a byte-level frame model
module tb_eth_rx;

  localparam int          HEAD_N = 54;
  localparam int          HEAD_W = HEAD_N / 2;
  localparam logic [47:0] MAC    = 48'h000000FCD4F2;
  localparam logic [31:0] IP     = {8'd206, 8'd200, 8'd127, 8'd128};
  localparam logic [15:0] PORT   = 16'd18170;

  logic        clk;
  logic        nreset;
  logic        pcs_valid_i;
  logic        pcs_start_i;
  logic [15:0] pcs_data_i;
  logic [1:0]  pcs_len_i;
  logic        pcs_last_i;
  logic        app_valid_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;
  logic        app_start_o;
  logic        app_last_o;
  logic        app_cancel_o;
  logic [15:0] pkt_len_o;

  eth_rx dut (
    .clk          (clk),
    .nreset       (nreset),
    .pcs_valid_i  (pcs_valid_i),
    .pcs_start_i  (pcs_start_i),
    .pcs_data_i   (pcs_data_i),
    .pcs_len_i    (pcs_len_i),
    .pcs_last_i   (pcs_last_i),
    .app_valid_o  (app_valid_o),
    .app_data_o   (app_data_o),
    .app_len_o    (app_len_o),
    .app_start_o  (app_start_o),
    .app_last_o   (app_last_o),
    .app_cancel_o (app_cancel_o),
    .pkt_len_o    (pkt_len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        s;
    logic        l;
  } rec_t;

  int          n_checks;
  int          n_errors;
  rec_t        obs_q[$];
  rec_t        exp_q[$];
  int          obs_cancel;
  int          obs_base;
  int          cancel_base;
  int          exp_cancel;
  logic [15:0] exp_pkt_len;
  logic [7:0]  fb[$];
  int          cur_pay;
  logic [15:0] cur_udp;
  bit          frame_ok;
  int          cur_corrupt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nreset && app_valid_o) obs_q.push_back('{app_data_o, app_len_o, app_start_o, app_last_o});
    if (app_cancel_o) obs_cancel++;
  end

  function automatic logic [7:0] fld(input int id, input logic [7:0] v);
    return (cur_corrupt == id) ? (v ^ 8'(1 + $urandom_range(0, 254))) : v;
  endfunction

  function automatic int n_words();
    return (HEAD_N + cur_pay + 1) / 2;
  endfunction

  task automatic build_frame(input int pay, input int corrupt, input logic [15:0] dport,
                             input logic [15:0] udp_len);
    cur_pay     = pay;
    cur_udp     = udp_len;
    cur_corrupt = corrupt;
    frame_ok    = (corrupt == 0) && (dport == PORT);
    fb.delete();
    for (int k = 0; k < 7; k++) fb.push_back(fld(1, 8'h55));
    fb.push_back(fld(2, 8'hD5));
    for (int k = 5; k >= 0; k--) fb.push_back(fld(3, MAC[8*k +: 8]));
    for (int k = 0; k < 6; k++) fb.push_back(8'($urandom));
    fb.push_back(fld(4, 8'h81));
    fb.push_back(8'h00);
    fb.push_back(8'($urandom));
    fb.push_back(8'($urandom));
    fb.push_back(fld(5, 8'h08));
    fb.push_back(8'h00);
    fb.push_back(fld(6, 8'h45));
    for (int k = 0; k < 8; k++) fb.push_back(8'($urandom));
    fb.push_back(fld(7, 8'd17));
    for (int k = 0; k < 6; k++) fb.push_back(8'($urandom));
    for (int k = 3; k >= 0; k--) fb.push_back(fld(8, IP[8*k +: 8]));
    fb.push_back(8'($urandom));
    fb.push_back(8'($urandom));
    fb.push_back(dport[15:8]);
    fb.push_back(dport[7:0]);
    fb.push_back(udp_len[15:8]);
    fb.push_back(udp_len[7:0]);
    fb.push_back(8'($urandom));
    fb.push_back(8'($urandom));
    for (int k = 0; k < pay; k++) fb.push_back(8'($urandom));
    if (fb.size() % 2 != 0) fb.push_back(8'($urandom));
  endtask

  task automatic expect_frame(input int limit);
    rec_t r;
    int   total;
    total = n_words();
    if (!frame_ok) return;
    for (int w = HEAD_W; w < limit; w++) begin
      r.data = {fb[2*w+1], fb[2*w]};
      r.s    = (w == HEAD_W);
      r.l    = (w == total - 1);
      r.len  = (r.l && (cur_pay % 2 != 0)) ? 2'd1 : 2'd2;
      exp_q.push_back(r);
    end
    if (limit > HEAD_W) exp_pkt_len = cur_udp - 16'd8;
  endtask

  task automatic send_range(input int from, input int to, input bit with_last, input int gap_mode);
    int idle;
    for (int w = from; w < to; w++) begin
      idle = 0;
      if (w > from) idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (idle) begin
        pcs_valid_i = 1'b0;
        pcs_data_i  = 16'($urandom);
        @(posedge clk);
        #1;
      end
      pcs_valid_i = 1'b1;
      pcs_start_i = (w == 0);
      pcs_last_i  = with_last && (w == to - 1);
      pcs_data_i  = {fb[2*w+1], fb[2*w]};
      pcs_len_i   = pcs_last_i ? ((cur_pay % 2 != 0) ? 2'd1 : 2'd2) : 2'($urandom);
      @(posedge clk);
      #1;
      pcs_valid_i = 1'b0;
      pcs_start_i = 1'b0;
      pcs_last_i  = 1'b0;
    end
  endtask

  task automatic compare_phase(input string tag);
    int n_obs;
    int n;
    repeat (3) @(posedge clk);
    #1;
    n_obs = obs_q.size() - obs_base;
    check_eq({tag, ".count"}, 64'(n_obs), 64'(exp_q.size()));
    n = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, ".data"},  64'(obs_q[obs_base+i].data), 64'(exp_q[i].data));
      check_eq({tag, ".len"},   64'(obs_q[obs_base+i].len),  64'(exp_q[i].len));
      check_eq({tag, ".start"}, 64'(obs_q[obs_base+i].s),    64'(exp_q[i].s));
      check_eq({tag, ".last"},  64'(obs_q[obs_base+i].l),    64'(exp_q[i].l));
    end
    check_eq({tag, ".cancel"},  64'(obs_cancel - cancel_base), 64'(exp_cancel));
    check_eq({tag, ".pkt_len"}, 64'(pkt_len_o), 64'(exp_pkt_len));
    exp_q.delete();
    exp_cancel  = 0;
    obs_base    = obs_q.size();
    cancel_base = obs_cancel;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid"},   64'(app_valid_o),  64'(0));
    check_eq({tag, ".data"},    64'(app_data_o),   64'(0));
    check_eq({tag, ".len"},     64'(app_len_o),    64'(0));
    check_eq({tag, ".start"},   64'(app_start_o),  64'(0));
    check_eq({tag, ".last"},    64'(app_last_o),   64'(0));
    check_eq({tag, ".cancel"},  64'(app_cancel_o), 64'(0));
    check_eq({tag, ".pkt_len"}, 64'(pkt_len_o),    64'(0));
  endtask

  initial begin
    int pay;
    int corrupt;
    int gap;
    logic [15:0] dport;
    logic [15:0] ulen;
    n_checks    = 0;
    n_errors    = 0;
    obs_base    = 0;
    cancel_base = 0;
    exp_cancel  = 0;
    exp_pkt_len = 16'd0;
    nreset      = 1'b0;
    pcs_valid_i = 1'b0;
    pcs_start_i = 1'b0;
    pcs_data_i  = 16'd0;
    pcs_len_i   = 2'd0;
    pcs_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    build_frame(4, 0, PORT, 16'd12);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("vlan4");
    check_eq("vlan4.pkt_len_const", 64'(pkt_len_o), 64'(4));

    build_frame(6, 0, 16'd18171, 16'd14);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("badport");

    build_frame(7, 0, PORT, 16'd15);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("b2b");
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 1);
    compare_phase("gapped");

    build_frame(1, 0, PORT, 16'd9);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("single");

    build_frame(10, 0, PORT, 16'd18);
    expect_frame(HEAD_W + 2);
    send_range(0, HEAD_W + 2, 1'b0, 0);
    exp_cancel = 1;
    build_frame(5, 0, PORT, 16'd13);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("cancel");

    build_frame(10, 0, PORT, 16'd18);
    expect_frame(HEAD_W + 2);
    send_range(0, HEAD_W + 2, 1'b0, 0);
    @(negedge clk);
    #1;
    nreset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_pkt_len = 16'd0;
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    send_range(HEAD_W + 2, n_words(), 1'b1, 0);
    build_frame(3, 0, PORT, 16'd4);
    expect_frame(n_words());
    send_range(0, n_words(), 1'b1, 0);
    compare_phase("after_reset");

    for (int f = 0; f < 12; f++) begin
      pay     = $urandom_range(1, 9);
      corrupt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      dport   = ($urandom_range(0, 7) == 0) ? (PORT ^ 16'($urandom_range(1, 65535))) : PORT;
      ulen    = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'(pay + 8);
      gap     = $urandom_range(0, 2);
      build_frame(pay, corrupt, dport, ulen);
      expect_frame(n_words());
      send_range(0, n_words(), 1'b1, gap);
      compare_phase($sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
